// File: rtl/pipeline_pkg.sv
// Shared constants and state encoding for the fetch-side pipeline control blocks.
package pipeline_pkg;

    localparam int                  PC_WIDTH         = 16;
    localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = '0;
    localparam int                  PC_INC           = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } redirect_state_e;

    // Instructions are halfword aligned, so a redirect target never carries bit 0.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones; cleared by the async active-low reset.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: sequential fetch, taken-branch redirect, IF/ID + ID/EX flush and bubble insertion.
module pc_redirect_unit #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  PC_INC       = 2,
    parameter int                  FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                branch_flush_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                fetch_valid_o,
    output logic                flush_ifid_o,
    output logic                flush_idex_o,
    output logic                busy_o,
    output logic [15:0]         redirect_count_o
);

    import pipeline_pkg::*;

    localparam logic [2:0]          FLUSH_CNT = 3'(FLUSH_CYCLES);
    localparam logic [PC_WIDTH-1:0] INC_W     = PC_WIDTH'(PC_INC);

    redirect_state_e     state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [2:0]          bub_q, bub_d;
    logic                redirect;
    logic                fetch_valid;
    logic                flush_ifid;
    logic                flush_idex;
    logic [PC_WIDTH-1:0] target_aligned;

    assign target_aligned = {branch_target_i[PC_WIDTH-1:1], 1'b0};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        bub_d       = bub_q;
        redirect    = 1'b0;
        fetch_valid = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        case (state_q)
            ST_RUN: begin
                fetch_valid = 1'b1;
                if (branch_flush_i) begin
                    // A taken redirect overrides any stall request.
                    redirect   = 1'b1;
                    pc_d       = target_aligned;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    if (FLUSH_CYCLES > 0) begin
                        state_d = ST_FLUSH;
                        bub_d   = FLUSH_CNT;
                    end
                end else if (!stall_i) begin
                    pc_d = pc_q + INC_W;
                end
            end
            ST_FLUSH: begin
                flush_ifid = 1'b1;
                if (branch_flush_i) begin
                    // Newest redirect wins: retarget and restart the bubble window.
                    redirect   = 1'b1;
                    pc_d       = target_aligned;
                    flush_idex = 1'b1;
                    bub_d      = FLUSH_CNT;
                end else if (!stall_i) begin
                    if (bub_q <= 3'd1) begin
                        state_d = ST_RUN;
                        bub_d   = 3'd0;
                    end else begin
                        bub_d = bub_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            bub_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bub_q   <= bub_d;
        end
    end

    sat_counter16 u_redirect_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (redirect),
        .count_o (redirect_count_o)
    );

    // Combinational outputs are gated so nothing leaks out while reset is held.
    assign pc_o          = pc_q;
    assign fetch_valid_o = rst_n & fetch_valid;
    assign flush_ifid_o  = rst_n & flush_ifid;
    assign flush_idex_o  = rst_n & flush_idex;
    assign busy_o        = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed and random bench for pc_redirect_unit against a bubble-counting reference model.
module tb_pc_redirect_unit;

    localparam int FC = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        branch_flush_i;
    logic [15:0] branch_target_i;
    logic [15:0] pc_o;
    logic        fetch_valid_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
    logic        busy_o;
    logic [15:0] redirect_count_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: next fetch address, bubbles still owed, redirects seen.
    logic [15:0] m_pc;
    int          m_bub;
    int          m_cnt;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .PC_WIDTH     (16),
        .RESET_PC     (16'h0000),
        .PC_INC       (2),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .branch_flush_i   (branch_flush_i),
        .branch_target_i  (branch_target_i),
        .pc_o             (pc_o),
        .fetch_valid_o    (fetch_valid_o),
        .flush_ifid_o     (flush_ifid_o),
        .flush_idex_o     (flush_idex_o),
        .busy_o           (busy_o),
        .redirect_count_o (redirect_count_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 16'h0000;
        m_bub = 0;
        m_cnt = 0;
    endtask

    // Called at a negedge: drive, check the cycle's outputs, advance the model, return at next negedge.
    task automatic step(input logic fl, input logic [15:0] tgt, input logic st);
        branch_flush_i  = fl;
        branch_target_i = tgt;
        stall_i         = st;
        #1;
        chk("pc",          pc_o,             m_pc);
        chk("fetch_valid", {15'd0, fetch_valid_o}, {15'd0, (m_bub == 0)});
        chk("busy",        {15'd0, busy_o},        {15'd0, (m_bub > 0)});
        chk("flush_ifid",  {15'd0, flush_ifid_o},  {15'd0, (fl || m_bub > 0)});
        chk("flush_idex",  {15'd0, flush_idex_o},  {15'd0, fl});
        chk("redir_count", redirect_count_o, 16'(m_cnt));
        @(posedge clk);
        if (fl) begin
            m_pc  = tgt & 16'hFFFE;
            m_bub = FC;
            if (m_cnt < 65535) m_cnt++;
        end else if (m_bub > 0) begin
            if (!st) m_bub--;
        end else if (!st) begin
            m_pc = m_pc + 16'd2;
        end
        @(negedge clk);
    endtask

    task automatic chk_in_reset();
        chk("rst_pc",          pc_o,                    16'h0000);
        chk("rst_fetch_valid", {15'd0, fetch_valid_o},  16'h0000);
        chk("rst_busy",        {15'd0, busy_o},         16'h0000);
        chk("rst_flush_ifid",  {15'd0, flush_ifid_o},   16'h0000);
        chk("rst_flush_idex",  {15'd0, flush_idex_o},   16'h0000);
        chk("rst_count",       redirect_count_o,        16'h0000);
    endtask

    initial begin
        stall_i         = 1'b0;
        branch_flush_i  = 1'b1;
        branch_target_i = 16'h1234;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_in_reset();
        @(negedge clk);
        rst_n          = 1'b1;
        branch_flush_i = 1'b0;
        model_reset();

        // Sequential fetch from reset PC
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        // Redirect at 0006 to odd target 0041
        step(1, 16'h0041, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        // Redirect beats stall, then stall inside the bubble window
        step(1, 16'h0100, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        // Back-to-back redirects: second lands during the bubble
        step(1, 16'h0100, 0);
        step(1, 16'h0200, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        // PC wrap
        step(1, 16'hFFFD, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        // Redirect counter saturation
        force dut.u_redirect_cnt.count_q = 16'hFFFE;
        #1;
        release dut.u_redirect_cnt.count_q;
        m_cnt = 16'hFFFE;
        step(1, 16'h0800, 0);
        step(0, 16'h0000, 0);
        step(1, 16'h0900, 0);
        step(0, 16'h0000, 0);
        step(1, 16'h0A00, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);

        // Fresh counts for the random phase
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 5) == 0), 16'($urandom_range(0, 65535)),
                 ($urandom_range(0, 3) == 0));
        end

        // Async reset in the middle of a flush window
        step(1, 16'h0300, 0);
        #2;
        rst_n          = 1'b0;
        branch_flush_i = 1'b1;
        #1;
        chk_in_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
